data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Memory-side responder for the core's load/store port: the slave end of the data-memory interface.
- Accepts one word read or write request per valid/ready handshake.
- Inserts a configurable number of wait states, then returns a response over a second valid/ready handshake.
- Backs a word-addressed RAM placed at a fixed base address, and flags misaligned or out-of-range accesses. Lets the pipelined core be exercised against a multi-cycle memory.

Parameters:
- DATA_WIDTH, 32, data word width in bits.
- MEMORY_DEPTH, 256, number of words in the RAM.
- BASE_ADDR, 32'h1001_0000, byte address of word 0.
- WAIT_STATES, 2, extra cycles between request acceptance and memory access (0..15).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request.
- req_write_i  input  1  1 = store, 0 = load.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  DATA_WIDTH  store data.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  requester accepts the response.
- rsp_rdata_o  output  DATA_WIDTH  load data; 0 for stores and errors.
- rsp_err_o  output  1  access was misaligned or out of range.
- busy_o  output  1  transaction outstanding (state != IDLE).

Behaviour:
- Reset (asynchronous, any state):
  - State becomes IDLE.
  - req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, busy_o=0, wait counter=0.
  - RAM contents are not cleared.
- States:
  - IDLE: req_ready_o=1.
  - WAIT: req_ready_o=0.
  - RESP: req_ready_o=0, rsp_valid_o=1.
  - req_ready_o and busy_o are decoded from state.
- IDLE -> WAIT:
  - Occurs on the edge where req_valid_i=1 (with req_ready_o=1).
  - Registers addr, write flag and wdata; loads the counter with WAIT_STATES.
  - req_valid_i while not in IDLE is ignored.
- WAIT:
  - While counter != 0, decrement each edge.
  - When counter == 0, the next edge performs the access and enters RESP.
  - Acceptance at edge t therefore gives rsp_valid_o=1 after edge t+WAIT_STATES+1. For WAIT_STATES=0 this is t+1.
- Address decode (on the registered address):
  - offset = addr - BASE_ADDR; word index = offset[log2(MEMORY_DEPTH)+1:2].
  - Error if any of: addr < BASE_ADDR; offset >= MEMORY_DEPTH*4; addr[1:0] != 0.
- Access (on the WAIT->RESP edge):
  - Valid store: writes RAM[index]; rsp_rdata_o=0; rsp_err_o=0.
  - Valid load: rsp_rdata_o=RAM[index]; rsp_err_o=0.
  - Error: no RAM write; rsp_rdata_o=0; rsp_err_o=1.
- RESP:
  - rsp_valid_o, rsp_rdata_o and rsp_err_o are held stable until an edge with rsp_ready_i=1.
  - That edge moves to IDLE and clears rsp_valid_o; rsp_rdata_o and rsp_err_o also return to 0.
- Throughput: the next request can be accepted on the edge after response completion. Minimum period is WAIT_STATES+3 cycles per transaction.
- Single outstanding transaction, so read/write ordering is program order; a load after a store to the same address returns the new data.
- Reset mid-operation:
  - Reset in WAIT aborts with no RAM write.
  - Reset in RESP drops the response; the RAM write already performed remains.
- Counter width: 4 bits. Offset arithmetic: 32-bit unsigned; the underflow case is caught by the addr < BASE_ADDR check.

Test Plan:
1. Reset reaction: assert reset asynchronously mid-cycle -> req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, busy_o=0 immediately.
2. Store then load, WAIT_STATES=2, rsp_ready_i=1:
   - Store 0xDEADBEEF to 0x1001_0004, accepted at edge t -> rsp_valid_o high after edge t+3, err=0, rdata=0.
   - Load 0x1001_0004 -> rdata=0xDEADBEEF.
3. Misaligned store: 0x1001_0002 data 0x12345678 -> err=1, rdata=0; a following load of 0x1001_0000 returns its prior value.
4. Range bounds: load 0x1001_0400 and 0x1000_FFFC -> err=1; load 0x1001_03FC -> err=0.
5. Backpressure: hold rsp_ready_i=0 for 5 cycles during a load response -> rsp_valid_o, rsp_rdata_o held; req_ready_o=0; a concurrent req_valid_i is ignored; rsp_ready_i=1 -> IDLE next edge.
6. Reset in WAIT during a store of 0xCAFEF00D to 0x1001_0008 -> after release, a load of 0x1001_0008 returns the old value, err=0.

Source files
------------

// File: rtl/data_memory_responder.sv
// Slave end of the core's data-memory port. Accepts one word load/store per
// request handshake, waits WAIT_STATES cycles, then performs the RAM access.
// The result is returned over a separate response handshake.
// Handshake rule, both channels: a transfer happens on a rising clk edge where
// valid and ready are both 1. Once the response valid is raised, it stays high
// and its payload stays stable until that transfer happens.
// Accesses that are misaligned or fall outside the RAM window are flagged with
// rsp_err_o and never touch the RAM.
module data_memory_responder #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          MEMORY_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
    parameter int          WAIT_STATES  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [31:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  busy_o
);

    localparam int          IDX_W     = $clog2(MEMORY_DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(MEMORY_DEPTH * 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              wait_cnt;
    logic [31:0]             addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   mem [MEMORY_DEPTH];

    logic [31:0]             offset;
    logic [IDX_W-1:0]        word_idx;
    logic                    addr_err;
    logic                    accept;
    logic                    access;

    // Address decode on the latched request; an address below the base wraps
    // the offset, so the explicit below-base test catches it.
    assign offset   = addr_q - BASE_ADDR;
    assign word_idx = offset[IDX_W+1:2];
    assign addr_err = (addr_q < BASE_ADDR) || (offset >= MEM_BYTES) ||
                      (addr_q[1:0] != 2'b00);

    assign accept = (state == IDLE) && req_valid_i;
    assign access = (state == WAIT) && (wait_cnt == 4'd0);

    assign req_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign rsp_valid_o = (state == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept, count down the wait states, hold the response.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid_i) state_next = WAIT;
            WAIT:    if (wait_cnt == 4'd0) state_next = RESP;
            RESP:    if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, wait counter and response payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
            addr_q   <= 32'd0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                wait_cnt <= 4'(WAIT_STATES);
                addr_q   <= req_addr_i;
                write_q  <= req_write_i;
                wdata_q  <= req_wdata_i;
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (access) begin
                err_q   <= addr_err;
                rdata_q <= (!write_q && !addr_err) ? mem[word_idx] : '0;
            end else if ((state == RESP) && rsp_ready_i) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    // RAM write port; contents survive reset, and a reset edge never writes.
    always_ff @(posedge clk) begin
        if (!reset && access && write_q && !addr_err) begin
            mem[word_idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder. Stimulus pushes the expected
// {err, rdata} of each response into exp_q; the monitor pops and compares on
// every response transfer and also checks request-to-response latency.
module tb_data_memory_responder;

    localparam int DW = 32;
    localparam int WS = 2;

    logic          clk;
    logic          reset;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_write_i;
    logic [31:0]   req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          busy_o;

    logic [DW:0]   exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            acc_cyc  = 0;
    logic          prev_valid = 1'b0;

    data_memory_responder #(
        .DATA_WIDTH  (DW),
        .MEMORY_DEPTH(256),
        .BASE_ADDR   (32'h1001_0000),
        .WAIT_STATES (WS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_write_i(req_write_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o),
        .busy_o     (busy_o)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("watchdog expired, aborting run");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rsp_valid_o && !prev_valid)
            check("rsp_latency", 64'(cyc - acc_cyc), 64'(WS + 1));
        if (rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                check("rsp_err", 64'(rsp_err_o), 64'(e[DW]));
                check("rsp_rdata", 64'(rsp_rdata_o), 64'(e[DW-1:0]));
            end
        end
        prev_valid = rsp_valid_o;
    end

    // Driver tasks
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [DW-1:0] wd,
                         input logic e, input logic [DW-1:0] rd, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            check("req_ready_timeout", 64'd0, 64'd1);
            return;
        end
        if (push) exp_q.push_back({e, rd});
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wd;
        @(posedge clk);
        #1;
        acc_cyc     = cyc;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid_o) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic txn(input logic wr, input logic [31:0] addr, input logic [DW-1:0] wd,
                       input logic e, input logic [DW-1:0] rd);
        issue(wr, addr, wd, e, rd, 1'b1);
        wait_idle();
    endtask

    // Directed stimulus
    initial begin
        reset       = 1'b0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = 32'd0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b1;

        // asynchronous reset asserted mid-cycle, outputs react at once
        #3 reset = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready_o), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata_o), 64'd0);
        check("rst_rsp_err",   64'(rsp_err_o),   64'd0);
        check("rst_busy",      64'(busy_o),      64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // store then load
        txn(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 1'b0, 32'h0);
        txn(1'b0, 32'h1001_0004, 32'h0,         1'b0, 32'hDEAD_BEEF);

        // misaligned store leaves word 0 untouched
        txn(1'b1, 32'h1001_0000, 32'h0000_A5A5, 1'b0, 32'h0);
        txn(1'b1, 32'h1001_0002, 32'h1234_5678, 1'b1, 32'h0);
        txn(1'b0, 32'h1001_0000, 32'h0,         1'b0, 32'h0000_A5A5);

        // range bounds
        txn(1'b0, 32'h1001_0400, 32'h0,         1'b1, 32'h0);
        txn(1'b0, 32'h1000_FFFC, 32'h0,         1'b1, 32'h0);
        txn(1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0);
        txn(1'b1, 32'h1001_03FC, 32'h600D_600D, 1'b0, 32'h0);
        txn(1'b0, 32'h1001_03FC, 32'h0,         1'b0, 32'h600D_600D);
        txn(1'b0, 32'h1001_0003, 32'h0,         1'b1, 32'h0);

        // backpressure with a competing request that must be ignored
        rsp_ready_i = 1'b0;
        issue(1'b0, 32'h1001_0004, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        wait_valid();
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 32'h1001_0004;
        req_wdata_i = 32'h1111_1111;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 64'(rsp_valid_o), 64'd1);
            check("bp_rsp_rdata", 64'(rsp_rdata_o), 64'hDEAD_BEEF);
            check("bp_req_ready", 64'(req_ready_o), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_busy",   64'(busy_o),      64'd0);
        check("bp_idle_valid",  64'(rsp_valid_o), 64'd0);
        check("bp_idle_rdata",  64'(rsp_rdata_o), 64'd0);
        check("bp_idle_ready",  64'(req_ready_o), 64'd1);
        txn(1'b0, 32'h1001_0004, 32'h0, 1'b0, 32'hDEAD_BEEF);

        // reset during WAIT aborts the store
        txn(1'b1, 32'h1001_0008, 32'h0BAD_C0DE, 1'b0, 32'h0);
        issue(1'b1, 32'h1001_0008, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
        check("wait_busy_before", 64'(busy_o), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("wait_rst_busy",  64'(busy_o),      64'd0);
        check("wait_rst_ready", 64'(req_ready_o), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        txn(1'b0, 32'h1001_0008, 32'h0, 1'b0, 32'h0BAD_C0DE);

        // reset during RESP drops the response but keeps the write
        rsp_ready_i = 1'b0;
        issue(1'b1, 32'h1001_000C, 32'h55AA_55AA, 1'b0, 32'h0, 1'b0);
        wait_valid();
        #2 reset = 1'b1;
        #1;
        check("resp_rst_valid", 64'(rsp_valid_o), 64'd0);
        check("resp_rst_err",   64'(rsp_err_o),   64'd0);
        check("resp_rst_rdata", 64'(rsp_rdata_o), 64'd0);
        check("resp_rst_ready", 64'(req_ready_o), 64'd1);
        check("resp_rst_busy",  64'(busy_o),      64'd0);
        @(negedge clk);
        reset = 1'b0;
        rsp_ready_i = 1'b1;
        txn(1'b0, 32'h1001_000C, 32'h0, 1'b0, 32'h55AA_55AA);

        // every expected response was delivered
        repeat (3) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
